// File: rtl/apb_master.sv
// APB initiator: takes single read/write commands on a valid/ready port and runs each
// one through the APB SETUP and ACCESS phases, returning a one-cycle response.
// Optional build macro APB_MASTER_PREADY_EN adds a PREADY input for completer wait states.
module apb_master #(
   parameter int unsigned AMBA_WORD       = 32,
   parameter int unsigned AMBA_ADDR_WIDTH = 20,
   parameter int unsigned CNT_WIDTH       = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       cmd_valid,
   output logic                       cmd_ready,
   input  logic                       cmd_write,
   input  logic [AMBA_ADDR_WIDTH-1:0] cmd_addr,
   input  logic [AMBA_WORD-1:0]       cmd_wdata,
   output logic                       rsp_valid,
   output logic                       rsp_write,
   output logic [AMBA_WORD-1:0]       rsp_rdata,
   output logic                       busy,
   output logic [CNT_WIDTH-1:0]       xfer_cnt,
   output logic                       PSEL,
   output logic                       PENABLE,
   output logic                       PWRITE,
   output logic [AMBA_ADDR_WIDTH-1:0] PADDR,
   output logic [AMBA_WORD-1:0]       PWDATA,
`ifdef APB_MASTER_PREADY_EN
   input  logic                       PREADY,
`endif
   input  logic [AMBA_WORD-1:0]       PRDATA
);

   typedef enum logic [1:0] {StIdle, StSetup, StAccess} state_e;

   state_e                     state_q, state_d;
   logic                       psel_q, psel_d;
   logic                       penable_q, penable_d;
   logic                       pwrite_q, pwrite_d;
   logic [AMBA_ADDR_WIDTH-1:0] paddr_q, paddr_d;
   logic [AMBA_WORD-1:0]       pwdata_q, pwdata_d;
   logic                       rsp_valid_q, rsp_valid_d;
   logic                       rsp_write_q, rsp_write_d;
   logic [AMBA_WORD-1:0]       rsp_rdata_q, rsp_rdata_d;
   logic                       busy_q, busy_d;
   logic [CNT_WIDTH-1:0]       xfer_cnt_q, xfer_cnt_d;
   logic                       done;

   // ACCESS finishes on PREADY when wait states are enabled, otherwise after one cycle.
`ifdef APB_MASTER_PREADY_EN
   assign done = (state_q == StAccess) && PREADY;
`else
   assign done = (state_q == StAccess);
`endif

   // A new command can be taken when idle or in the same edge the current one completes.
   always_comb begin
      cmd_ready = (state_q == StIdle) || done;
   end

   // Next-state and next-value logic for the bus and response registers.
   always_comb begin
      state_d     = state_q;
      psel_d      = psel_q;
      penable_d   = penable_q;
      pwrite_d    = pwrite_q;
      paddr_d     = paddr_q;
      pwdata_d    = pwdata_q;
      rsp_valid_d = 1'b0;
      rsp_write_d = rsp_write_q;
      rsp_rdata_d = rsp_rdata_q;
      xfer_cnt_d  = xfer_cnt_q;

      case (state_q)
         StIdle: begin
            if (cmd_valid) begin
               state_d   = StSetup;
               psel_d    = 1'b1;
               penable_d = 1'b0;
               pwrite_d  = cmd_write;
               paddr_d   = {cmd_addr[AMBA_ADDR_WIDTH-1:2], 2'b00};
               pwdata_d  = cmd_wdata;
            end
         end
         StSetup: begin
            state_d   = StAccess;
            penable_d = 1'b1;
         end
         StAccess: begin
            if (done) begin
               rsp_valid_d = 1'b1;
               rsp_write_d = pwrite_q;
               if (!pwrite_q) begin
                  rsp_rdata_d = PRDATA;
               end
               xfer_cnt_d = xfer_cnt_q + CNT_WIDTH'(1);
               if (cmd_valid) begin
                  // Back-to-back: PSEL stays high, straight into the next SETUP.
                  state_d   = StSetup;
                  penable_d = 1'b0;
                  pwrite_d  = cmd_write;
                  paddr_d   = {cmd_addr[AMBA_ADDR_WIDTH-1:2], 2'b00};
                  pwdata_d  = cmd_wdata;
               end else begin
                  state_d   = StIdle;
                  psel_d    = 1'b0;
                  penable_d = 1'b0;
               end
            end
         end
         default: begin
            state_d   = StIdle;
            psel_d    = 1'b0;
            penable_d = 1'b0;
         end
      endcase

      busy_d = (state_d != StIdle);
   end

   // State and output registers; every bus-facing output comes straight from a flop.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= StIdle;
         psel_q      <= 1'b0;
         penable_q   <= 1'b0;
         pwrite_q    <= 1'b0;
         paddr_q     <= '0;
         pwdata_q    <= '0;
         rsp_valid_q <= 1'b0;
         rsp_write_q <= 1'b0;
         rsp_rdata_q <= '0;
         busy_q      <= 1'b0;
         xfer_cnt_q  <= '0;
      end else begin
         state_q     <= state_d;
         psel_q      <= psel_d;
         penable_q   <= penable_d;
         pwrite_q    <= pwrite_d;
         paddr_q     <= paddr_d;
         pwdata_q    <= pwdata_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_write_q <= rsp_write_d;
         rsp_rdata_q <= rsp_rdata_d;
         busy_q      <= busy_d;
         xfer_cnt_q  <= xfer_cnt_d;
      end
   end

   assign PSEL      = psel_q;
   assign PENABLE   = penable_q;
   assign PWRITE    = pwrite_q;
   assign PADDR     = paddr_q;
   assign PWDATA    = pwdata_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_write = rsp_write_q;
   assign rsp_rdata = rsp_rdata_q;
   assign busy      = busy_q;
   assign xfer_cnt  = xfer_cnt_q;

endmodule

// File: tb/tb_apb_master.sv
// Self-checking bench for apb_master: directed transfers from the bring-up list, a reset
// abort in ACCESS, then randomized commands, all compared every cycle against a
// transfer-level reference model. The counter is built narrow so that wrap is reached.
module tb_apb_master;

   localparam int unsigned DW = 32;
   localparam int unsigned AW = 20;
   localparam int unsigned CW = 4;

   logic          clk;
   logic          rst;
   logic          cmd_valid;
   logic          cmd_ready;
   logic          cmd_write;
   logic [AW-1:0] cmd_addr;
   logic [DW-1:0] cmd_wdata;
   logic          rsp_valid;
   logic          rsp_write;
   logic [DW-1:0] rsp_rdata;
   logic          busy;
   logic [CW-1:0] xfer_cnt;
   logic          psel;
   logic          penable;
   logic          pwrite;
   logic [AW-1:0] paddr;
   logic [DW-1:0] pwdata;
   logic [DW-1:0] prdata;
   logic          pready;

   int n_checks;
   int n_errors;

   apb_master #(
      .AMBA_WORD       (DW),
      .AMBA_ADDR_WIDTH (AW),
      .CNT_WIDTH       (CW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_write (cmd_write),
      .cmd_addr  (cmd_addr),
      .cmd_wdata (cmd_wdata),
      .rsp_valid (rsp_valid),
      .rsp_write (rsp_write),
      .rsp_rdata (rsp_rdata),
      .busy      (busy),
      .xfer_cnt  (xfer_cnt),
      .PSEL      (psel),
      .PENABLE   (penable),
      .PWRITE    (pwrite),
      .PADDR     (paddr),
      .PWDATA    (pwdata),
`ifdef APB_MASTER_PREADY_EN
      .PREADY    (pready),
`endif
      .PRDATA    (prdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: one outstanding transfer, tracked as cycles since its acceptance
   // (0 = nothing in flight, 1 = first bus cycle, 2 = enable cycle, possibly waiting).
   int            m_age;
   logic          m_acc;
   logic          m_done;
   logic          m_write;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_wdata;
   logic          m_rsp_valid;
   logic          m_rsp_write;
   logic [DW-1:0] m_rdata;
   logic [CW-1:0] m_cnt;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_age = 0; m_acc = 0; m_write = 0; m_addr = '0; m_wdata = '0;
         m_rsp_valid = 0; m_rsp_write = 0; m_rdata = '0; m_cnt = '0;
      end else begin
         m_done      = (m_age == 2) && pready;
         m_acc       = cmd_valid && ((m_age == 0) || m_done);
         m_rsp_valid = m_done;
         if (m_done) begin
            m_rsp_write = m_write;
            if (!m_write) m_rdata = prdata;
            m_cnt = m_cnt + 1'b1;
         end
         if (m_acc) begin
            m_age   = 1;
            m_write = cmd_write;
            m_addr  = cmd_addr & ~AW'(3);
            m_wdata = cmd_wdata;
         end else if (m_age == 1) begin
            m_age = 2;
         end else if (m_done) begin
            m_age = 0;
         end
      end
   end

   bit chk_en;
   always @(negedge clk) begin
      if (chk_en) begin
         check("cmd_ready", cmd_ready, (m_age == 0) || ((m_age == 2) && pready));
         check("psel", psel, m_age != 0);
         check("penable", penable, m_age == 2);
         check("busy", busy, m_age != 0);
         check("pwrite", pwrite, m_write);
         check("paddr", paddr, m_addr);
         check("pwdata", pwdata, m_wdata);
         check("rsp_valid", rsp_valid, m_rsp_valid);
         check("rsp_write", rsp_write, m_rsp_write);
         check("rsp_rdata", rsp_rdata, m_rdata);
         check("xfer_cnt", xfer_cnt, m_cnt);
      end
   end

   // Completer: fresh PRDATA (and PREADY when enabled) each cycle unless pinned.
   bit            fix_en;
   logic [DW-1:0] fix_val;
   always @(posedge clk) begin
      #1;
      prdata = fix_en ? fix_val : $urandom;
`ifdef APB_MASTER_PREADY_EN
      pready = ($urandom_range(0, 3) != 0);
`else
      pready = 1'b1;
`endif
   end

   task automatic send(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] data);
      int n;
      cmd_valid = 1'b1;
      cmd_write = wr;
      cmd_addr  = addr;
      cmd_wdata = data;
      n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (!m_acc && n < 100);
      if (!m_acc) check("accept_timeout", 0, 1);
      cmd_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      cmd_valid = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: simulation did not end");
      $fatal(1, "timeout");
   end

   initial begin
      n_checks  = 0;
      n_errors  = 0;
      chk_en    = 0;
      fix_en    = 0;
      fix_val   = '0;
      cmd_valid = 0;
      cmd_write = 0;
      cmd_addr  = '0;
      cmd_wdata = '0;
      prdata    = '0;
      pready    = 1'b1;
      rst       = 1'b0;
      #23;
      check("rst_psel", psel, 0);
      check("rst_paddr", paddr, 0);
      check("rst_cnt", xfer_cnt, 0);
      check("rst_busy", busy, 0);
      rst = 1'b1;
      chk_en = 1;
      @(posedge clk);
      #1;

      // Directed: write, read with pinned PRDATA, back-to-back, unaligned address.
      fix_en  = 1;
      fix_val = 32'h0000_0010;
      send(1'b1, 20'h00004, 32'hA5A5_0001);
      idle(4);
      send(1'b0, 20'h00008, 32'h0);
      idle(4);
      send(1'b1, 20'h00000, 32'h1234_5678);
      send(1'b0, 20'h0000C, 32'h0);
      idle(4);
      send(1'b0, 20'h00007, 32'h0);
      idle(4);
      fix_en = 0;

      // Reset abort while in ACCESS.
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 20'h00004; cmd_wdata = 32'hCAFE_0000;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      @(posedge clk);
      #1;
      check("abort_in_access", penable, 1);
      #2;
      rst = 1'b0;
      #1;
      check("abort_psel", psel, 0);
      check("abort_penable", penable, 0);
      check("abort_busy", busy, 0);
      check("abort_cnt", xfer_cnt, 0);
      check("abort_rsp", rsp_valid, 0);
      @(posedge clk);
      #3;
      rst = 1'b1;
      idle(2);

      // Randomized traffic; more than 2^CW completions so the counter wraps.
      for (int i = 0; i < 300; i++) begin
         send($urandom_range(0, 1) == 1, AW'($urandom), $urandom);
         if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
      end
      idle(8);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
